multi_cycle_control: RTL and testbench
======================================

MULTI_CYCLE_CONTROL -- requirements
Module: multi_cycle_control

Interface
REQ-001 SHALL have ports, in this order:
- CLK  in  1  system clock, rising edge
- RST  in  1  asynchronous, active-low reset
- opcode  in  6  instruction opcode from the instruction register
- zero  in  1  ALU zero flag
- state  out  3  current state
- PCWre, IRWre, InsMemRW, ALUSrcB, mRD, mWR, RegWre, DBDataSrc, WrRegDSrc  out  1 each  datapath strobes and selects
- RegDst  out  2  00=$31, 01=rt, 10=rd
- PCSrc  out  2  00=PC+4, 01=branch, 10=jr, 11=jump
- ALUOp  out  3  ALU function
- halted  out  1  processor stopped
- retired  out  16  count of completed instructions

REQ-002 SHALL use the following parameters (name, default, meaning):
- IF, 3'b000, fetch
- ID, 3'b001, decode
- aEXE, 3'b110, ALU execute
- bEXE, 3'b101, branch execute
- cEXE, 3'b010, address execute
- MEM, 3'b011, memory access
- aWB, 3'b111, ALU writeback
- cWB, 3'b100, load writeback

Function
REQ-003 The state register SHALL update on every rising CLK edge, except while halted=1.
REQ-004 Transitions SHALL be:
- IF -> ID
- ID, opcode[5:3]=110: beq (110100) -> bEXE; otherwise -> cEXE
- ID, opcode[5:3]=111 -> IF
- ID, any other opcode -> aEXE
- aEXE -> aWB; bEXE -> IF; cEXE -> MEM
- MEM: lw (110001) -> cWB; otherwise -> IF
- aWB -> IF; cWB -> IF
- Any unlisted state code -> IF

REQ-005 Outputs SHALL be combinational from state, opcode and zero; every strobe not listed below SHALL be 0, and RegDst, PCSrc and ALUOp SHALL be 00/00/000 unless listed.
REQ-006 IF: IRWre=1, InsMemRW=1.
REQ-007 ID, j (111000): PCWre=1, PCSrc=11.
REQ-008 ID, jal (111010): PCWre=1, PCSrc=11, RegWre=1, WrRegDSrc=0, RegDst=00.
REQ-009 ID, jr (111001): PCWre=1, PCSrc=10.
REQ-010 ID, halt (111111): all strobes SHALL be 0.
REQ-011 aEXE: ALUOp=opcode[2:0]; ALUSrcB=1 when opcode[5:3]=010, else 0.
REQ-012 aWB: RegWre=1, WrRegDSrc=1, DBDataSrc=0, PCWre=1, ALUOp=opcode[2:0]; RegDst=10 when opcode[5:3]=000, else 01.
REQ-013 bEXE: ALUOp=001, PCWre=1; PCSrc=01 when zero=1, else 00.
REQ-014 cEXE: ALUSrcB=1, ALUOp=000.
REQ-015 MEM (ALUSrcB=1 held): lw gives mRD=1; sw (110000) gives mWR=1 and PCWre=1.
REQ-016 cWB: RegWre=1, WrRegDSrc=1, DBDataSrc=1, RegDst=01, PCWre=1.
REQ-017 halt decoded in ID SHALL set halted=1 at the next edge. The state SHALL then go to IF and hold there, and all strobes, IRWre included, SHALL be forced to 0 until reset.
REQ-018 retired SHALL increment by 1 on each edge where state is not IF and the next state is IF. halt SHALL NOT increment it.
REQ-019 retired SHALL wrap from 16'hFFFF to 16'h0000.
REQ-020 Instruction latencies SHALL be: j/jal/jr 2 cycles, beq 3, sw 4, R/I-type ALU 4, lw 5.

Reset
REQ-021 RST=0 SHALL immediately, without waiting for a clock edge, set state=IF, halted=0 and retired=0, including mid-instruction.
REQ-022 While in reset, outputs SHALL equal the IF decode: IRWre=1, InsMemRW=1, all others 0.
REQ-023 The first rising edge after RST deasserts SHALL move the state IF -> ID.

Verification
REQ-024 add (000000) -> states IF, ID, aEXE, aWB, IF. In aWB: RegWre=1, RegDst=10, PCWre=1. retired goes 0 -> 1.
REQ-025 beq with zero=1 -> states IF, ID, bEXE; PCSrc=01 and PCWre=1 in bEXE. With zero=0 -> PCSrc=00.
REQ-026 lw then sw:
- lw -> mRD=1 in MEM, cWB has DBDataSrc=1, 5 cycles.
- sw -> mWR=1 and PCWre=1 in MEM, then IF, 4 cycles.
- retired=2.
REQ-027 jal -> in ID: PCSrc=11, RegWre=1, RegDst=00, WrRegDSrc=0; next state IF.
REQ-028 halt -> halted=1 after ID. State holds IF for 20+ cycles with all strobes 0 and retired unchanged.
REQ-029 RST pulled low during MEM of lw -> state=IF immediately. No cWB follows; retired=0.

Source files
------------

// File: rtl/multi_cycle_control.sv
// Multi-cycle CPU control unit: state sequencer, combinational datapath
// decode, halt latch and retired-instruction counter.
module multi_cycle_control #(
    parameter logic [2:0] IF   = 3'b000,
    parameter logic [2:0] ID   = 3'b001,
    parameter logic [2:0] aEXE = 3'b110,
    parameter logic [2:0] bEXE = 3'b101,
    parameter logic [2:0] cEXE = 3'b010,
    parameter logic [2:0] MEM  = 3'b011,
    parameter logic [2:0] aWB  = 3'b111,
    parameter logic [2:0] cWB  = 3'b100
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic [5:0]  opcode,
    input  logic        zero,
    output logic [2:0]  state,
    output logic        PCWre,
    output logic        IRWre,
    output logic        InsMemRW,
    output logic        ALUSrcB,
    output logic        mRD,
    output logic        mWR,
    output logic        RegWre,
    output logic        DBDataSrc,
    output logic        WrRegDSrc,
    output logic [1:0]  RegDst,
    output logic [1:0]  PCSrc,
    output logic [2:0]  ALUOp,
    output logic        halted,
    output logic [15:0] retired
);

    localparam logic [5:0] OP_BEQ  = 6'b110100;
    localparam logic [5:0] OP_LW   = 6'b110001;
    localparam logic [5:0] OP_SW   = 6'b110000;
    localparam logic [5:0] OP_J    = 6'b111000;
    localparam logic [5:0] OP_JR   = 6'b111001;
    localparam logic [5:0] OP_JAL  = 6'b111010;
    localparam logic [5:0] OP_HALT = 6'b111111;

    logic [2:0] next_state;
    logic       halt_dec;
    logic       retire;

    assign halt_dec = (state == ID) && (opcode == OP_HALT);
    // An instruction completes when the sequencer returns to fetch; halt is not counted.
    assign retire   = !halted && (state != IF) && (next_state == IF) && !halt_dec;

    // Next-state selection by instruction class.
    always_comb begin
        next_state = IF;
        case (state)
            IF:   next_state = ID;
            ID: begin
                if (opcode[5:3] == 3'b110)
                    next_state = (opcode == OP_BEQ) ? bEXE : cEXE;
                else if (opcode[5:3] == 3'b111)
                    next_state = IF;
                else
                    next_state = aEXE;
            end
            aEXE: next_state = aWB;
            bEXE: next_state = IF;
            cEXE: next_state = MEM;
            MEM:  next_state = (opcode == OP_LW) ? cWB : IF;
            aWB:  next_state = IF;
            cWB:  next_state = IF;
            default: next_state = IF;
        endcase
    end

    // State register; frozen once the processor has halted.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST)
            state <= IF;
        else if (!halted)
            state <= next_state;
    end

    // Halt latch: set by halt in decode, cleared only by reset.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST)
            halted <= 1'b0;
        else if (halt_dec)
            halted <= 1'b1;
    end

    // Retired-instruction counter, wraps naturally at 16 bits.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST)
            retired <= 16'h0000;
        else if (retire)
            retired <= retired + 16'h0001;
    end

    // Datapath strobes decoded from state, opcode and zero; all quiet when halted.
    always_comb begin
        PCWre     = 1'b0;
        IRWre     = 1'b0;
        InsMemRW  = 1'b0;
        ALUSrcB   = 1'b0;
        mRD       = 1'b0;
        mWR       = 1'b0;
        RegWre    = 1'b0;
        DBDataSrc = 1'b0;
        WrRegDSrc = 1'b0;
        RegDst    = 2'b00;
        PCSrc     = 2'b00;
        ALUOp     = 3'b000;
        if (!halted) begin
            case (state)
                IF: begin
                    IRWre    = 1'b1;
                    InsMemRW = 1'b1;
                end
                ID: begin
                    case (opcode)
                        OP_J: begin
                            PCWre = 1'b1;
                            PCSrc = 2'b11;
                        end
                        OP_JAL: begin
                            PCWre  = 1'b1;
                            PCSrc  = 2'b11;
                            RegWre = 1'b1;
                        end
                        OP_JR: begin
                            PCWre = 1'b1;
                            PCSrc = 2'b10;
                        end
                        default: ;
                    endcase
                end
                aEXE: begin
                    ALUOp   = opcode[2:0];
                    ALUSrcB = (opcode[5:3] == 3'b010);
                end
                aWB: begin
                    RegWre    = 1'b1;
                    WrRegDSrc = 1'b1;
                    PCWre     = 1'b1;
                    ALUOp     = opcode[2:0];
                    RegDst    = (opcode[5:3] == 3'b000) ? 2'b10 : 2'b01;
                end
                bEXE: begin
                    ALUOp = 3'b001;
                    PCWre = 1'b1;
                    PCSrc = zero ? 2'b01 : 2'b00;
                end
                cEXE: begin
                    ALUSrcB = 1'b1;
                end
                MEM: begin
                    ALUSrcB = 1'b1;
                    if (opcode == OP_LW)
                        mRD = 1'b1;
                    if (opcode == OP_SW) begin
                        mWR   = 1'b1;
                        PCWre = 1'b1;
                    end
                end
                cWB: begin
                    RegWre    = 1'b1;
                    WrRegDSrc = 1'b1;
                    DBDataSrc = 1'b1;
                    RegDst    = 2'b01;
                    PCWre     = 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_multi_cycle_control.sv
// Scoreboard bench for multi_cycle_control: an instruction-level model pushes
// the expected per-cycle state/strobes; a monitor pops and compares.
module tb_multi_cycle_control;

    logic        CLK, RST, zero;
    logic [5:0]  opcode;
    logic [2:0]  state;
    logic        PCWre, IRWre, InsMemRW, ALUSrcB, mRD, mWR, RegWre, DBDataSrc, WrRegDSrc;
    logic [1:0]  RegDst, PCSrc;
    logic [2:0]  ALUOp;
    logic        halted;
    logic [15:0] retired;

    multi_cycle_control dut (
        .CLK(CLK), .RST(RST), .opcode(opcode), .zero(zero), .state(state),
        .PCWre(PCWre), .IRWre(IRWre), .InsMemRW(InsMemRW), .ALUSrcB(ALUSrcB),
        .mRD(mRD), .mWR(mWR), .RegWre(RegWre), .DBDataSrc(DBDataSrc),
        .WrRegDSrc(WrRegDSrc), .RegDst(RegDst), .PCSrc(PCSrc), .ALUOp(ALUOp),
        .halted(halted), .retired(retired)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // State codes
    localparam logic [2:0] S_IF = 3'b000, S_ID = 3'b001, S_AEXE = 3'b110, S_BEXE = 3'b101;
    localparam logic [2:0] S_CEXE = 3'b010, S_MEM = 3'b011, S_AWB = 3'b111, S_CWB = 3'b100;

    // Control word: {PCWre,IRWre,InsMemRW,ALUSrcB,mRD,mWR,RegWre,DBDataSrc,WrRegDSrc,RegDst,PCSrc,ALUOp}
    localparam logic [15:0] PCW = 16'h8000, IRW = 16'h4000, IMR = 16'h2000, ASB = 16'h1000;
    localparam logic [15:0] MRD = 16'h0800, MWR = 16'h0400, RGW = 16'h0200, DBS = 16'h0100;
    localparam logic [15:0] WRS = 16'h0080, RD_RD = 16'h0040, RD_RT = 16'h0020;
    localparam logic [15:0] PC_J = 16'h0018, PC_JR = 16'h0010, PC_BR = 16'h0008;

    typedef struct packed {
        logic [2:0]  st;
        logic        h;
        logic [15:0] ret;
        logic [15:0] ctl;
    } exp_t;

    exp_t        sb[$];
    logic [15:0] ret;      // model of the retired counter
    int          tests = 0;
    int          fails = 0;
    event        probe_ev;

    task automatic push(input logic [2:0] st, input logic [15:0] ctl, input logic h);
        exp_t e;
        e.st = st; e.h = h; e.ret = ret; e.ctl = ctl;
        sb.push_back(e);
    endtask

    // Monitor: compare DUT outputs against the oldest expectation.
    initial begin
        exp_t e, a;
        forever begin
            @(negedge CLK or probe_ev);
            if (sb.size() > 0) begin
                e = sb.pop_front();
                a.st = state; a.h = halted; a.ret = retired;
                a.ctl = {PCWre, IRWre, InsMemRW, ALUSrcB, mRD, mWR, RegWre, DBDataSrc,
                         WrRegDSrc, RegDst, PCSrc, ALUOp};
                tests++;
                if (a !== e) begin
                    fails++;
                    $display("FAIL cycle_check #%0d op=%b: got st=%h h=%b ret=%h ctl=%h, want st=%h h=%b ret=%h ctl=%h",
                             tests, opcode, a.st, a.h, a.ret, a.ctl, e.st, e.h, e.ret, e.ctl);
                end
            end
        end
    end

    // Instruction-level model: expected cycle trace per instruction class.
    task automatic run_instr(input logic [5:0] op, input logic z, input int halt_hold);
        int          n;
        logic [2:0]  g;
        logic        is_halt;
        logic [15:0] c;
        g = op[5:3];
        is_halt = (op == 6'b111111);
        opcode = op;
        zero = z;
        n = 0;
        push(S_IF, IRW | IMR, 1'b0); n++;
        if (g == 3'b111) begin
            c = 16'h0000;
            if (op == 6'b111000) c = PCW | PC_J;
            if (op == 6'b111010) c = PCW | PC_J | RGW;
            if (op == 6'b111001) c = PCW | PC_JR;
            push(S_ID, c, 1'b0); n++;
            if (is_halt)
                for (int i = 0; i < halt_hold; i++) begin
                    push(S_IF, 16'h0000, 1'b1); n++;
                end
        end else if (g == 3'b110) begin
            push(S_ID, 16'h0000, 1'b0); n++;
            if (op == 6'b110100) begin
                push(S_BEXE, PCW | 16'h0001 | (z ? PC_BR : 16'h0000), 1'b0); n++;
            end else begin
                push(S_CEXE, ASB, 1'b0); n++;
                c = ASB;
                if (op == 6'b110001) c = c | MRD;
                if (op == 6'b110000) c = c | MWR | PCW;
                push(S_MEM, c, 1'b0); n++;
                if (op == 6'b110001) begin
                    push(S_CWB, RGW | WRS | DBS | RD_RT | PCW, 1'b0); n++;
                end
            end
        end else begin
            push(S_ID, 16'h0000, 1'b0); n++;
            push(S_AEXE, ((g == 3'b010) ? ASB : 16'h0000) | {13'd0, op[2:0]}, 1'b0); n++;
            push(S_AWB, RGW | WRS | PCW | ((g == 3'b000) ? RD_RD : RD_RT) | {13'd0, op[2:0]}, 1'b0); n++;
        end
        repeat (n) @(posedge CLK);
        #1;
        if (!is_halt) ret = ret + 16'h0001;
    endtask

    // Asynchronous reset mid-cycle, checked before any clock edge.
    task automatic async_reset();
        @(negedge CLK);
        #1;
        RST = 1'b0;
        ret = 16'h0000;
        #1;
        push(S_IF, IRW | IMR, 1'b0);
        -> probe_ev;
        @(posedge CLK);
        #1;
        RST = 1'b1;
    endtask

    initial begin
        logic [5:0] op;
        int         k;
        RST = 1'b0;
        opcode = 6'd0;
        zero = 1'b0;
        ret = 16'h0000;
        @(posedge CLK);
        #1;
        repeat (2) begin
            push(S_IF, IRW | IMR, 1'b0);
            @(posedge CLK);
            #1;
        end
        RST = 1'b1;

        // Directed: add, beq taken/not taken, lw, sw, jal, j, jr, addi-like
        run_instr(6'b000000, 1'b0, 0);
        run_instr(6'b110100, 1'b1, 0);
        run_instr(6'b110100, 1'b0, 0);
        run_instr(6'b110001, 1'b0, 0);
        run_instr(6'b110000, 1'b0, 0);
        run_instr(6'b111010, 1'b0, 0);
        run_instr(6'b111000, 1'b1, 0);
        run_instr(6'b111001, 1'b0, 0);
        run_instr(6'b010011, 1'b0, 0);

        // Randomized instruction stream
        for (int i = 0; i < 60; i++) begin
            case ($urandom_range(0, 4))
                0: op = {3'($urandom_range(0, 5)), 3'($urandom)};
                1: op = 6'b110100;
                2: op = 6'b110001;
                3: op = {3'b110, 3'($urandom)};
                default: begin
                    op = {3'b111, 3'($urandom)};
                    if (op == 6'b111111) op = 6'b111010;
                end
            endcase
            run_instr(op, 1'($urandom), 0);
        end

        // Reset during MEM of lw: no writeback follows, counter cleared
        opcode = 6'b110001;
        zero = 1'b0;
        push(S_IF, IRW | IMR, 1'b0);
        push(S_ID, 16'h0000, 1'b0);
        push(S_CEXE, ASB, 1'b0);
        push(S_MEM, ASB | MRD, 1'b0);
        repeat (3) @(posedge CLK);
        #1;
        async_reset();
        run_instr(6'b000001, 1'b0, 0);
        run_instr(6'b110000, 1'b0, 0);

        // Halt: frozen in IF, strobes quiet, counter unchanged
        run_instr(6'b111111, 1'b0, 24);
        async_reset();
        run_instr(6'b000000, 1'b1, 0);
        run_instr(6'b110001, 1'b0, 0);

        k = 0;
        while (sb.size() > 0 && k < 20) begin
            @(negedge CLK);
            k++;
        end
        if (sb.size() > 0) begin
            tests++;
            fails++;
            $display("FAIL drain: %0d expectations left, want 0", sb.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
